// File: rtl/mem_arb_if.sv
// Request/response and memory-side bus bundle for mem_arb.
// The arbiter uses the slave view; the pipeline/memory environment uses master.
interface mem_arb_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rdy;
    logic [DATA_W-1:0] i_data;
    logic              i_stall;

    logic              d_re;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rdy;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic [ADDR_W-1:0] m_addr;
    logic              m_re;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_re, d_we, d_addr, d_wdata, m_rdata,
        output i_rdy, i_data, i_stall, d_rdy, d_rdata, d_stall,
               m_addr, m_re, m_we, m_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_re, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdy, i_data, i_stall, d_rdy, d_rdata, d_stall,
               m_addr, m_re, m_we, m_wdata, busy
    );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one fixed-latency memory between the
// instruction-fetch and data-access ports; one access in flight at a time.
module mem_arb #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LAT    = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_arb_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              last_q,    last_d;
    logic              gnt_q,     gnt_d;
    logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              m_re_q,    m_re_d;
    logic              m_we_q,    m_we_d;
    logic              i_rdy_q,   i_rdy_d;
    logic              d_rdy_q,   d_rdy_d;
    logic [DATA_W-1:0] i_data_q,  i_data_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic d_req;
    logic win_d;
    logic win_wr;

    // On contention the port that did not win last time is granted.
    always_comb begin
        d_req  = bus.d_re | bus.d_we;
        win_d  = d_req & ~(bus.i_req & (last_q == PORT_D));
        win_wr = win_d & bus.d_we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= PORT_I;
            gnt_q     <= PORT_I;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_re_q    <= 1'b0;
            m_we_q    <= 1'b0;
            i_rdy_q   <= 1'b0;
            d_rdy_q   <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_re_q    <= m_re_d;
            m_we_q    <= m_we_d;
            i_rdy_q   <= i_rdy_d;
            d_rdy_q   <= d_rdy_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_re_d    = m_re_q;
        m_we_d    = m_we_q;
        i_rdy_d   = 1'b0;
        d_rdy_d   = 1'b0;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req | d_req) begin
                    gnt_d     = win_d;
                    last_d    = win_d;
                    m_addr_d  = win_d ? bus.d_addr : bus.i_addr;
                    m_wdata_d = win_d ? bus.d_wdata : '0;
                    m_we_d    = win_wr;
                    m_re_d    = ~win_wr;
                    cnt_d     = CNT_INIT;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // Memory data is valid only in the final access cycle.
                if (cnt_q == '0) begin
                    if (m_re_q) begin
                        if (gnt_q == PORT_D) begin
                            d_rdata_d = bus.m_rdata;
                        end else begin
                            i_data_d = bus.m_rdata;
                        end
                    end
                    m_re_d  = 1'b0;
                    m_we_d  = 1'b0;
                    i_rdy_d = (gnt_q == PORT_I);
                    d_rdy_d = (gnt_q == PORT_D);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_re    = m_re_q;
    assign bus.m_we    = m_we_q;
    assign bus.i_rdy   = i_rdy_q;
    assign bus.d_rdy   = d_rdy_q;
    assign bus.i_data  = i_data_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = (state_q != IDLE);

    // Stalls react to the live request so the pipeline freezes in the request cycle.
    assign bus.i_stall = bus.i_req & ~i_rdy_q;
    assign bus.d_stall = d_req & ~d_rdy_q;
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus randomized traffic against a
// transaction-level model of grant times, access windows and captured data.
module tb_mem_arb;
    localparam int unsigned LAT0 = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    bit   fix_rd;
    logic [15:0] fix_val;

    mem_arb_if #(.ADDR_W(16), .DATA_W(16)) b0 ();
    mem_arb_if #(.ADDR_W(16), .DATA_W(16)) b1 ();

    mem_arb #(.ADDR_W(16), .DATA_W(16), .LAT(LAT0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mem_arb #(.ADDR_W(16), .DATA_W(16), .LAT(1))    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: one access record with its grant cycle t_g.
    int unsigned cyc;
    int unsigned t_g;
    bit          t_val, t_port, t_we, last_dp;
    logic [15:0] t_addr, t_wdata;
    logic [15:0] e_m_addr, e_m_wdata, e_i_data, e_d_rdata;
    bit          e_m_re, e_m_we, e_i_rdy, e_d_rdy, e_busy;

    always @(posedge clk) begin
        bit live;
        bit dreq;
        bit pick_d;
        if (!rst_n) begin
            t_val = 0; last_dp = 0;
            e_m_addr = '0; e_m_wdata = '0; e_i_data = '0; e_d_rdata = '0;
        end else begin
            live = t_val && (cyc >= t_g + 1) && (cyc <= t_g + LAT0 + 1);
            if (t_val && !t_we && cyc == t_g + LAT0) begin
                if (t_port) e_d_rdata = b0.m_rdata;
                else        e_i_data  = b0.m_rdata;
            end
            dreq = (b0.d_re === 1'b1) || (b0.d_we === 1'b1);
            if (!live && (b0.i_req === 1'b1 || dreq)) begin
                pick_d    = dreq && !(b0.i_req === 1'b1 && last_dp);
                t_val     = 1;
                t_port    = pick_d;
                t_g       = cyc;
                last_dp   = pick_d;
                t_we      = pick_d && (b0.d_we === 1'b1);
                t_addr    = pick_d ? b0.d_addr : b0.i_addr;
                t_wdata   = pick_d ? b0.d_wdata : 16'h0000;
                e_m_addr  = t_addr;
                e_m_wdata = t_wdata;
            end
        end
        cyc++;
        e_busy  = t_val && (cyc >= t_g + 1) && (cyc <= t_g + LAT0 + 1);
        e_m_re  = t_val && !t_we && (cyc >= t_g + 1) && (cyc <= t_g + LAT0);
        e_m_we  = t_val &&  t_we && (cyc >= t_g + 1) && (cyc <= t_g + LAT0);
        e_i_rdy = t_val && !t_port && (cyc == t_g + LAT0 + 1);
        e_d_rdy = t_val &&  t_port && (cyc == t_g + LAT0 + 1);
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
        b0.m_rdata = fix_rd ? fix_val : 16'($urandom);
        b1.m_rdata = 16'hBEEF;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        next_cyc();
        next_cyc();
        @(negedge clk);
        checks++;
        if ({b0.m_re, b0.m_we, b0.i_rdy, b0.d_rdy, b0.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {b0.m_re, b0.m_we, b0.i_rdy, b0.d_rdy, b0.busy});
        end
        checks++;
        if (b0.m_addr !== 16'h0) begin errors++; $display("FAIL reset_m_addr: got %h want 0000", b0.m_addr); end
        checks++;
        if (b0.m_wdata !== 16'h0) begin errors++; $display("FAIL reset_m_wdata: got %h want 0000", b0.m_wdata); end
        checks++;
        if (b0.i_data !== 16'h0) begin errors++; $display("FAIL reset_i_data: got %h want 0000", b0.i_data); end
        checks++;
        if (b0.d_rdata !== 16'h0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0000", b0.d_rdata); end
        checks++;
        if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_lat1: got %b want 0", b1.busy); end
        next_cyc();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({b0.i_stall, b0.d_stall, b0.busy} !== 3'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b want 000", {b0.i_stall, b0.d_stall, b0.busy});
        end
    endtask

    task automatic test_single_read();
        fix_rd = 1; fix_val = 16'hA5A5;
        for (int k = 0; k <= 6; k++) begin
            next_cyc();
            if (k == 0) begin b0.i_req = 1'b1; b0.i_addr = 16'h0010; end
            if (k == 6) b0.i_req = 1'b0;
            @(negedge clk);
            checks++;
            if (b0.m_re !== 1'((k >= 1) && (k <= 4))) begin errors++; $display("FAIL rd_m_re cyc%0d: got %b", k, b0.m_re); end
            if (k >= 1 && k <= 4) begin
                checks++;
                if (b0.m_addr !== 16'h0010) begin errors++; $display("FAIL rd_m_addr cyc%0d: got %h want 0010", k, b0.m_addr); end
            end
            checks++;
            if (b0.i_rdy !== 1'(k == 5)) begin errors++; $display("FAIL rd_i_rdy cyc%0d: got %b", k, b0.i_rdy); end
            checks++;
            if (b0.i_stall !== 1'(k <= 4)) begin errors++; $display("FAIL rd_i_stall cyc%0d: got %b", k, b0.i_stall); end
            if (k == 5) begin
                checks++;
                if (b0.i_data !== 16'hA5A5) begin errors++; $display("FAIL rd_i_data: got %h want a5a5", b0.i_data); end
            end
        end
        fix_rd = 0;
    endtask

    task automatic test_d_write(input bit also_re, input logic [15:0] addr, input logic [15:0] wdata);
        logic [15:0] prev;
        prev = e_d_rdata;
        for (int k = 0; k <= 6; k++) begin
            next_cyc();
            if (k == 0) begin b0.d_we = 1'b1; b0.d_re = also_re; b0.d_addr = addr; b0.d_wdata = wdata; end
            if (k == 6) begin b0.d_we = 1'b0; b0.d_re = 1'b0; end
            @(negedge clk);
            checks++;
            if (b0.m_re !== 1'b0) begin errors++; $display("FAIL wr_m_re re=%0d cyc%0d: got %b want 0", also_re, k, b0.m_re); end
            checks++;
            if (b0.m_we !== 1'((k >= 1) && (k <= 4))) begin errors++; $display("FAIL wr_m_we re=%0d cyc%0d: got %b", also_re, k, b0.m_we); end
            if (k >= 1 && k <= 4) begin
                checks++;
                if ({b0.m_addr, b0.m_wdata} !== {addr, wdata}) begin
                    errors++; $display("FAIL wr_bus cyc%0d: got %h/%h want %h/%h", k, b0.m_addr, b0.m_wdata, addr, wdata);
                end
            end
            checks++;
            if ({b0.d_rdy, b0.i_rdy} !== {1'(k == 5), 1'b0}) begin errors++; $display("FAIL wr_rdy cyc%0d: got %b", k, {b0.d_rdy, b0.i_rdy}); end
        end
        checks++;
        if (b0.d_rdata !== prev) begin errors++; $display("FAIL wr_d_rdata_kept: got %h want %h", b0.d_rdata, prev); end
    endtask

    task automatic test_contention();
        next_cyc();
        rst_n = 1'b0;
        for (int k = 0; k <= 25; k++) begin
            next_cyc();
            if (k == 0) begin
                rst_n = 1'b1; b0.i_req = 1'b1; b0.d_re = 1'b1; b0.d_we = 1'b0;
                b0.i_addr = 16'h0100; b0.d_addr = 16'h0200;
            end
            if (k == 24) begin b0.i_req = 1'b0; b0.d_re = 1'b0; end
            @(negedge clk);
            checks++;
            if ({b0.i_rdy, b0.d_rdy} !== {1'(k == 11 || k == 23), 1'(k == 5 || k == 17)}) begin
                errors++; $display("FAIL rr_rdy cyc%0d: got i/d=%b", k, {b0.i_rdy, b0.d_rdy});
            end
            if (k == 1 || k == 7 || k == 13 || k == 19) begin
                checks++;
                if (b0.m_addr !== ((k == 1 || k == 13) ? 16'h0200 : 16'h0100)) begin
                    errors++; $display("FAIL rr_order cyc%0d: got m_addr %h", k, b0.m_addr);
                end
            end
            if (k == 5 || k == 17) begin
                checks++;
                if (b0.d_rdata !== e_d_rdata) begin errors++; $display("FAIL rr_d_rdata cyc%0d: got %h want %h", k, b0.d_rdata, e_d_rdata); end
            end
            if (k == 11 || k == 23) begin
                checks++;
                if (b0.i_data !== e_i_data) begin errors++; $display("FAIL rr_i_data cyc%0d: got %h want %h", k, b0.i_data, e_i_data); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k <= 10; k++) begin
            next_cyc();
            if (k == 0) begin b0.d_re = 1'b1; b0.d_addr = 16'h0222; end
            if (k == 2) rst_n = 1'b0;
            if (k == 3) begin rst_n = 1'b1; b0.d_re = 1'b0; end
            if (k == 4) begin b0.i_req = 1'b1; b0.i_addr = 16'h0ABC; end
            if (k == 10) b0.i_req = 1'b0;
            @(negedge clk);
            checks++;
            if (b0.d_rdy !== 1'b0) begin errors++; $display("FAIL mid_d_rdy cyc%0d: got %b want 0", k, b0.d_rdy); end
            if (k == 2) begin
                checks++;
                if (b0.m_re !== 1'b1) begin errors++; $display("FAIL mid_pre_m_re: got %b want 1", b0.m_re); end
            end
            if (k == 3) begin
                checks++;
                if ({b0.m_re, b0.busy, b0.m_addr, b0.d_rdata} !== 34'h0) begin
                    errors++; $display("FAIL mid_abandon: got re=%b busy=%b addr=%h rdata=%h", b0.m_re, b0.busy, b0.m_addr, b0.d_rdata);
                end
            end
            if (k == 5) begin
                checks++;
                if ({b0.m_re, b0.m_addr} !== {1'b1, 16'h0ABC}) begin errors++; $display("FAIL mid_regrant: got re=%b addr=%h", b0.m_re, b0.m_addr); end
            end
            checks++;
            if (b0.i_rdy !== 1'(k == 9)) begin errors++; $display("FAIL mid_i_rdy cyc%0d: got %b", k, b0.i_rdy); end
        end
    endtask

    task automatic test_lat1();
        for (int k = 0; k <= 4; k++) begin
            next_cyc();
            if (k == 0) begin b1.i_req = 1'b1; b1.i_addr = 16'h1234; end
            if (k == 1) b1.i_addr = 16'hFFFF;
            if (k == 3) b1.i_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({b1.m_re, b1.i_rdy, b1.busy} !== {1'(k == 1), 1'(k == 2), 1'(k == 1 || k == 2)}) begin
                errors++; $display("FAIL lat1_ctrl cyc%0d: got re/rdy/busy=%b", k, {b1.m_re, b1.i_rdy, b1.busy});
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (b1.m_addr !== 16'h1234) begin errors++; $display("FAIL lat1_m_addr cyc%0d: got %h want 1234", k, b1.m_addr); end
            end
            if (k == 2) begin
                checks++;
                if (b1.i_data !== 16'hBEEF) begin errors++; $display("FAIL lat1_i_data: got %h want beef", b1.i_data); end
            end
        end
    endtask

    task automatic test_random();
        bit ip, dp, pri, prd;
        int unsigned op;
        logic [6:0] got, exp;
        ip = 0; dp = 0;
        for (int n = 0; n < 800; n++) begin
            pri = e_i_rdy; prd = e_d_rdy;
            next_cyc();
            rst_n = ($urandom_range(0, 149) != 0);
            if (pri) ip = 0;
            if (prd) dp = 0;
            if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; b0.i_addr = 16'($urandom); end
            else if (ip && $urandom_range(0, 7) == 0) b0.i_addr = 16'($urandom);
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; op = $urandom_range(0, 2);
                b0.d_addr = 16'($urandom); b0.d_wdata = 16'($urandom);
                b0.d_re = (op != 1); b0.d_we = (op != 0);
            end else if (dp && $urandom_range(0, 7) == 0) b0.d_wdata = 16'($urandom);
            if (ip && $urandom_range(0, 59) == 0) ip = 0;
            if (dp && $urandom_range(0, 59) == 0) dp = 0;
            b0.i_req = ip;
            if (!dp) begin b0.d_re = 1'b0; b0.d_we = 1'b0; end
            @(negedge clk);
            got = {b0.m_re, b0.m_we, b0.i_rdy, b0.d_rdy, b0.busy, b0.i_stall, b0.d_stall};
            exp = {e_m_re, e_m_we, e_i_rdy, e_d_rdy, e_busy, ip && !e_i_rdy, dp && !e_d_rdy};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL rnd_ctrl n%0d: got %b want %b", n, got, exp); end
            checks++;
            if (b0.m_addr !== e_m_addr) begin errors++; $display("FAIL rnd_m_addr n%0d: got %h want %h", n, b0.m_addr, e_m_addr); end
            checks++;
            if (b0.m_wdata !== e_m_wdata) begin errors++; $display("FAIL rnd_m_wdata n%0d: got %h want %h", n, b0.m_wdata, e_m_wdata); end
            checks++;
            if (b0.i_data !== e_i_data) begin errors++; $display("FAIL rnd_i_data n%0d: got %h want %h", n, b0.i_data, e_i_data); end
            checks++;
            if (b0.d_rdata !== e_d_rdata) begin errors++; $display("FAIL rnd_d_rdata n%0d: got %h want %h", n, b0.d_rdata, e_d_rdata); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; fix_rd = 0; fix_val = '0;
        rst_n = 1'b0;
        b0.i_req = 0; b0.i_addr = '0; b0.d_re = 0; b0.d_we = 0; b0.d_addr = '0; b0.d_wdata = '0; b0.m_rdata = '0;
        b1.i_req = 0; b1.i_addr = '0; b1.d_re = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0; b1.m_rdata = '0;
        test_reset();
        test_single_read();
        test_d_write(1'b0, 16'h0040, 16'h1234);
        test_d_write(1'b1, 16'h0080, 16'hCAFE);
        test_contention();
        test_reset_midflight();
        test_lat1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port memory arbiter that shares one unified, fixed-latency memory between the pipeline's instruction-fetch port and data-access port. Each access is latched at grant, held on the memory bus for LAT cycles, and answered with a one-cycle ready pulse carrying registered read data. The block sits between the fetch/MEM stages and a single-ported backing memory. Its stall outputs freeze the pipeline while a port waits.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LAT, 4, memory access latency in cycles; legal range 1..15
- clk  in  1  global clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- i_req  in  1  instruction read request; held until i_rdy
- i_addr  in  ADDR_W  instruction address
- i_rdy  out  1  one-cycle pulse; i_data valid
- i_data  out  DATA_W  registered instruction read data
- i_stall  out  1  i_req & ~i_rdy (combinational)
- d_re  in  1  data read request; held until d_rdy
- d_we  in  1  data write request; held until d_rdy
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdy  out  1  one-cycle pulse; access complete, d_rdata valid for reads
- d_rdata  out  DATA_W  registered data read result
- d_stall  out  1  (d_re | d_we) & ~d_rdy (combinational)
- m_addr  out  ADDR_W  memory address, registered
- m_re  out  1  memory read strobe, registered
- m_we  out  1  memory write strobe, registered
- m_wdata  out  DATA_W  memory write data, registered
- m_rdata  in  DATA_W  memory read data; valid in the last cycle of an access
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY, RESP. A 4-bit down-counter `cnt` runs in BUSY.
- IDLE with no request: hold state.
- IDLE with a request: arbitrate, latch the winner's addr, wdata and op into the m_* registers, set cnt = LAT-1, go to BUSY.
- Arbitration is round-robin on contention and uses the `last` bit.
  - I only: I wins. D only: D wins.
  - Both requesting: the port that is not `last` wins.
  - `last` updates to the winner on every grant. Reset value of `last` is I, so the first contended grant goes to D.
- D op: d_we=1 means write, even if d_re=1 as well (write wins). Otherwise it is a read.
- BUSY:
  - m_* stay constant for exactly LAT cycles.
  - When cnt == 0: capture m_rdata into i_data (I read) or d_rdata (D read); a D write leaves d_rdata unchanged.
  - On that same edge: clear m_re/m_we, set the granted port's rdy, go to RESP.
  - Otherwise cnt decrements.
- RESP:
  - Exactly one cycle with the granted rdy = 1. No arbitration happens in this cycle, so a requester that drops its request on rdy is never re-granted.
  - Next state is IDLE, and rdy clears.
- Requester inputs are sampled only at grant. Changing addr/wdata, or dropping the request, during BUSY does not affect the access, and rdy still pulses.
- i_data/d_rdata hold their value until the next read completes on that port.

## Timing
- Request high in IDLE cycle t:
  - grant at edge t→t+1
  - m_* asserted for cycles t+1..t+LAT
  - rdy high in cycle t+LAT+1
  - IDLE in cycle t+LAT+2
- Back-to-back throughput is one access per LAT+2 cycles.
- With both ports continuously requesting, grants alternate D, I, D, I…
- Waiting-port bound: a port waits at most one full access (LAT+2 cycles) before its own grant.
- Reset (rst_n low at an edge, any state):
  - Next cycle: state=IDLE, cnt=0, last=I.
  - m_re=m_we=0, m_addr=m_wdata=0.
  - i_rdy=d_rdy=0, i_data=d_rdata=0, busy=0.
  - An in-flight access is abandoned with no rdy pulse.
- LAT=1: BUSY lasts one cycle, and rdy is high in cycle t+2.

## Test plan
- Single I read, LAT=4, i_addr=0x0010, memory returns 0xA5A5 → m_re high cycles 1-4 with m_addr=0x0010; i_rdy high only in cycle 5 with i_data=0xA5A5; i_stall high cycles 0-4.
- D write in cycle 0, addr 0x0040, wdata 0x1234 → m_we high 4 cycles with m_wdata=0x1234; d_rdy pulse in cycle 5; d_rdata unchanged.
- i_req and d_re both high from reset, held continuously → grant order D, I, D, I; each rdy spaced 6 cycles apart; i_rdy and d_rdy never both high.
- d_re=d_we=1 simultaneously → write performed; m_re never high.
- rst_n low during cycle 2 of a D read → m_re=0 from the next cycle; no d_rdy; busy=0; a new i_req afterwards is granted first (last=I, uncontended).
- LAT=1, i_addr changed to 0xFFFF during BUSY → m_addr keeps the grant-time value; i_rdy in cycle 2.
